// File: rtl/dual_issue_scheduler_pkg.sv
// Shared definitions for the dual-issue scheduler: FSM state encoding and default widths.
package dual_issue_scheduler_pkg;

    typedef enum logic {
        S_PAIR   = 1'b0,
        S_SECOND = 1'b1
    } schedState_t;

    localparam int DefaultRfAddrWidth = 5;
    localparam int DefaultCntWidth    = 32;

endpackage

// File: rtl/dual_issue_scheduler_pair_conflict_check.sv
// Purely combinational intra-pair conflict detector; a conflict forces the pair to split.
module pair_conflict_check
    import dual_issue_scheduler_pkg::*;
#(
    parameter int RF_ADDR_WIDTH = DefaultRfAddrWidth
) (
    input  logic [RF_ADDR_WIDTH-1:0] rdAddr0,
    input  logic                     rdWrtEn0,
    input  logic                     isMem0,
    input  logic                     isMulDiv0,
    input  logic                     isBranch0,
    input  logic [RF_ADDR_WIDTH-1:0] rs1Addr1,
    input  logic [RF_ADDR_WIDTH-1:0] rs2Addr1,
    input  logic [RF_ADDR_WIDTH-1:0] rdAddr1,
    input  logic                     rdWrtEn1,
    input  logic                     isMem1,
    input  logic                     isMulDiv1,
    output logic                     split
);

    logic rd0Live;
    logic rawHazard;
    logic wawHazard;

    assign rd0Live   = rdWrtEn0 && (rdAddr0 != '0);
    assign rawHazard = rd0Live && ((rdAddr0 == rs1Addr1) || (rdAddr0 == rs2Addr1));
    assign wawHazard = rd0Live && rdWrtEn1 && (rdAddr0 == rdAddr1);

    // A branch in slot 0 always splits so slot 1 never issues down a mispredicted path.
    assign split = rawHazard || wawHazard || (isMem0 && isMem1) ||
                   (isMulDiv0 && isMulDiv1) || isBranch0;

endmodule

// File: rtl/dual_issue_scheduler.sv
// Issue-stage scheduler: decides dual issue, split or hold for each decoded pair and drives IDEX lanes.
module dual_issue_scheduler
    import dual_issue_scheduler_pkg::*;
#(
    parameter int RF_ADDR_WIDTH = DefaultRfAddrWidth,
    parameter int CNT_WIDTH     = DefaultCntWidth
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     Flush,
    input  logic                     Decode_Valid_0,
    input  logic                     Decode_Valid_1,
    input  logic [RF_ADDR_WIDTH-1:0] Decode_Rs1Addr_0,
    input  logic [RF_ADDR_WIDTH-1:0] Decode_Rs1Addr_1,
    input  logic [RF_ADDR_WIDTH-1:0] Decode_Rs2Addr_0,
    input  logic [RF_ADDR_WIDTH-1:0] Decode_Rs2Addr_1,
    input  logic [RF_ADDR_WIDTH-1:0] Decode_RdAddr_0,
    input  logic [RF_ADDR_WIDTH-1:0] Decode_RdAddr_1,
    input  logic                     Decode_RdWrtEn_0,
    input  logic                     Decode_RdWrtEn_1,
    input  logic                     Decode_IsMem_0,
    input  logic                     Decode_IsMem_1,
    input  logic                     Decode_IsLd_0,
    input  logic                     Decode_IsLd_1,
    input  logic                     Decode_IsMulDiv_0,
    input  logic                     Decode_IsMulDiv_1,
    input  logic                     Decode_IsBranch_0,
    input  logic                     Decode_IsBranch_1,
    input  logic [RF_ADDR_WIDTH-1:0] IDEX_RdAddr_0,
    input  logic [RF_ADDR_WIDTH-1:0] IDEX_RdAddr_1,
    input  logic                     IDEX_IsLd_0,
    input  logic                     IDEX_IsLd_1,
    input  logic                     MulDiv_Busy,
    output logic                     Sched_DecodeReady,
    output logic                     Sched_IssueValid_0,
    output logic                     Sched_IssueValid_1,
    output logic                     Sched_IssueSwap,
    output logic [CNT_WIDTH-1:0]     Sched_SplitCnt,
    output logic [CNT_WIDTH-1:0]     Sched_StallCnt
);

    schedState_t state;
    schedState_t stateNext;
    logic        split;
    logic        hold0;
    logic        hold1;
    logic        valid0Next;
    logic        valid1Next;
    logic        swapNext;
    logic        splitInc;
    logic        stallInc;

    // Load-use: a nonzero source matches the Rd of a load currently in either EX lane.
    function automatic logic loadUse(
        input logic [RF_ADDR_WIDTH-1:0] rs1,
        input logic [RF_ADDR_WIDTH-1:0] rs2,
        input logic [RF_ADDR_WIDTH-1:0] exRd0,
        input logic                     exLd0,
        input logic [RF_ADDR_WIDTH-1:0] exRd1,
        input logic                     exLd1
    );
        logic hit1;
        logic hit2;
        hit1 = (rs1 != '0) && ((exLd0 && rs1 == exRd0) || (exLd1 && rs1 == exRd1));
        hit2 = (rs2 != '0) && ((exLd0 && rs2 == exRd0) || (exLd1 && rs2 == exRd1));
        return hit1 || hit2;
    endfunction

    assign hold0 = loadUse(Decode_Rs1Addr_0, Decode_Rs2Addr_0, IDEX_RdAddr_0, IDEX_IsLd_0,
                           IDEX_RdAddr_1, IDEX_IsLd_1) || (Decode_IsMulDiv_0 && MulDiv_Busy);
    assign hold1 = loadUse(Decode_Rs1Addr_1, Decode_Rs2Addr_1, IDEX_RdAddr_0, IDEX_IsLd_0,
                           IDEX_RdAddr_1, IDEX_IsLd_1) || (Decode_IsMulDiv_1 && MulDiv_Busy);

    pair_conflict_check #(
        .RF_ADDR_WIDTH(RF_ADDR_WIDTH)
    ) conflictCheck (
        .rdAddr0  (Decode_RdAddr_0),
        .rdWrtEn0 (Decode_RdWrtEn_0),
        .isMem0   (Decode_IsMem_0),
        .isMulDiv0(Decode_IsMulDiv_0),
        .isBranch0(Decode_IsBranch_0),
        .rs1Addr1 (Decode_Rs1Addr_1),
        .rs2Addr1 (Decode_Rs2Addr_1),
        .rdAddr1  (Decode_RdAddr_1),
        .rdWrtEn1 (Decode_RdWrtEn_1),
        .isMem1   (Decode_IsMem_1),
        .isMulDiv1(Decode_IsMulDiv_1),
        .split    (split)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= S_PAIR;
            Sched_IssueValid_0 <= 1'b0;
            Sched_IssueValid_1 <= 1'b0;
            Sched_IssueSwap    <= 1'b0;
        end else begin
            state              <= stateNext;
            Sched_IssueValid_0 <= valid0Next;
            Sched_IssueValid_1 <= valid1Next;
            Sched_IssueSwap    <= swapNext;
        end
    end

    // Priority: flush, then hold, then split, then dual issue. In S_SECOND only slot 1 matters.
    always_comb begin
        stateNext         = state;
        valid0Next        = 1'b0;
        valid1Next        = 1'b0;
        swapNext          = 1'b0;
        splitInc          = 1'b0;
        stallInc          = 1'b0;
        Sched_DecodeReady = 1'b0;
        if (Flush) begin
            stateNext         = S_PAIR;
            Sched_DecodeReady = 1'b1;
        end else if (state == S_SECOND) begin
            if (hold1) begin
                stallInc = 1'b1;
            end else begin
                valid0Next        = 1'b1;
                swapNext          = 1'b1;
                Sched_DecodeReady = 1'b1;
                stateNext         = S_PAIR;
            end
        end else if (!Decode_Valid_0) begin
            stateNext = S_PAIR;
        end else if (hold0) begin
            stallInc = 1'b1;
        end else if (!Decode_Valid_1 || split || hold1) begin
            valid0Next = 1'b1;
            if (Decode_Valid_1) begin
                splitInc  = 1'b1;
                stateNext = S_SECOND;
            end else begin
                Sched_DecodeReady = 1'b1;
            end
        end else begin
            valid0Next        = 1'b1;
            valid1Next        = 1'b1;
            Sched_DecodeReady = 1'b1;
        end
    end

    // Performance counters saturate at all-ones; a flush cycle never increments.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Sched_SplitCnt <= '0;
            Sched_StallCnt <= '0;
        end else if (!Flush) begin
            if (splitInc && (Sched_SplitCnt != '1)) begin
                Sched_SplitCnt <= Sched_SplitCnt + 1'b1;
            end
            if (stallInc && (Sched_StallCnt != '1)) begin
                Sched_StallCnt <= Sched_StallCnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Randomized self-checking bench for dual_issue_scheduler against a behavioural issue model.
module tb_dual_issue_scheduler;

    localparam int AW     = 5;
    localparam int CW     = 4;
    localparam int CntMax = (1 << CW) - 1;

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] rs1;
        logic [AW-1:0] rs2;
        logic [AW-1:0] rd;
        logic          wen;
        logic          isMem;
        logic          isLd;
        logic          isMulDiv;
        logic          isBranch;
    } slot_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    logic busy = 1'b0;
    slot_t s0 = '0;
    slot_t s1 = '0;
    logic [AW-1:0] exRd0 = '0;
    logic [AW-1:0] exRd1 = '0;
    logic exLd0 = 1'b0;
    logic exLd1 = 1'b0;

    logic          decodeReady;
    logic          issueValid0;
    logic          issueValid1;
    logic          issueSwap;
    logic [CW-1:0] splitCnt;
    logic [CW-1:0] stallCnt;

    int checkCount = 0;
    int failCount  = 0;

    // Reference model: whether slot 1 is still owed, expected lane outputs and counters.
    bit mPending = 0;
    bit mV0 = 0;
    bit mV1 = 0;
    bit mSwap = 0;
    int mSplit = 0;
    int mStall = 0;
    bit mReady = 0;

    always #5 clk = ~clk;

    dual_issue_scheduler #(
        .RF_ADDR_WIDTH(AW),
        .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst), .Flush(flush),
        .Decode_Valid_0(s0.valid), .Decode_Valid_1(s1.valid),
        .Decode_Rs1Addr_0(s0.rs1), .Decode_Rs1Addr_1(s1.rs1),
        .Decode_Rs2Addr_0(s0.rs2), .Decode_Rs2Addr_1(s1.rs2),
        .Decode_RdAddr_0(s0.rd), .Decode_RdAddr_1(s1.rd),
        .Decode_RdWrtEn_0(s0.wen), .Decode_RdWrtEn_1(s1.wen),
        .Decode_IsMem_0(s0.isMem), .Decode_IsMem_1(s1.isMem),
        .Decode_IsLd_0(s0.isLd), .Decode_IsLd_1(s1.isLd),
        .Decode_IsMulDiv_0(s0.isMulDiv), .Decode_IsMulDiv_1(s1.isMulDiv),
        .Decode_IsBranch_0(s0.isBranch), .Decode_IsBranch_1(s1.isBranch),
        .IDEX_RdAddr_0(exRd0), .IDEX_RdAddr_1(exRd1),
        .IDEX_IsLd_0(exLd0), .IDEX_IsLd_1(exLd1),
        .MulDiv_Busy(busy),
        .Sched_DecodeReady(decodeReady),
        .Sched_IssueValid_0(issueValid0), .Sched_IssueValid_1(issueValid1),
        .Sched_IssueSwap(issueSwap),
        .Sched_SplitCnt(splitCnt), .Sched_StallCnt(stallCnt)
    );

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checkCount++;
        if (actual != expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, actual, expected, $time);
        end
    endtask

    // True when the instruction must wait on a load in EX or on the busy mul/div unit.
    function automatic bit mustWait(input slot_t s);
        bit waitLoad;
        waitLoad = 0;
        foreach (s.rs1[i]) begin end
        if (s.rs1 != 0 && ((exLd0 && s.rs1 == exRd0) || (exLd1 && s.rs1 == exRd1))) waitLoad = 1;
        if (s.rs2 != 0 && ((exLd0 && s.rs2 == exRd0) || (exLd1 && s.rs2 == exRd1))) waitLoad = 1;
        return waitLoad || (s.isMulDiv && busy);
    endfunction

    function automatic bit pairClash(input slot_t a, input slot_t b);
        bit aWrites;
        aWrites = a.wen && a.rd != 0;
        return (aWrites && (a.rd == b.rs1 || a.rd == b.rs2 || (b.wen && a.rd == b.rd))) ||
               (a.isMem && b.isMem) || (a.isMulDiv && b.isMulDiv) || a.isBranch;
    endfunction

    task automatic resetModel();
        mPending = 0; mV0 = 0; mV1 = 0; mSwap = 0; mSplit = 0; mStall = 0;
    endtask

    // Drive the current inputs for one cycle, predict the outcome, and compare both edges.
    task automatic applyStimulus(input string tag);
        bit nV0, nV1, nSwap, nPending;
        nV0 = 0; nV1 = 0; nSwap = 0; nPending = mPending; mReady = 0;
        #1;
        if (flush) begin
            mReady = 1; nPending = 0;
        end else if (mPending) begin
            if (mustWait(s1)) begin
                mStall = (mStall < CntMax) ? mStall + 1 : mStall;
            end else begin
                nV0 = 1; nSwap = 1; mReady = 1; nPending = 0;
            end
        end else if (s0.valid) begin
            if (mustWait(s0)) begin
                mStall = (mStall < CntMax) ? mStall + 1 : mStall;
            end else if (!s1.valid || pairClash(s0, s1) || mustWait(s1)) begin
                nV0 = 1;
                if (s1.valid) begin
                    nPending = 1;
                    mSplit = (mSplit < CntMax) ? mSplit + 1 : mSplit;
                end else begin
                    mReady = 1;
                end
            end else begin
                nV0 = 1; nV1 = 1; mReady = 1;
            end
        end
        checkOutput({tag, ".ready"}, int'(decodeReady), int'(mReady));
        @(posedge clk);
        #1;
        mV0 = nV0; mV1 = nV1; mSwap = nSwap; mPending = nPending;
        checkOutput({tag, ".v0"}, int'(issueValid0), int'(mV0));
        checkOutput({tag, ".v1"}, int'(issueValid1), int'(mV1));
        checkOutput({tag, ".swap"}, int'(issueSwap), int'(mSwap));
        checkOutput({tag, ".split"}, int'(splitCnt), mSplit);
        checkOutput({tag, ".stall"}, int'(stallCnt), mStall);
    endtask

    function automatic slot_t aluOp(input int rd, input int rs1, input int rs2);
        slot_t s;
        s = '0;
        s.valid = 1; s.wen = 1;
        s.rd = AW'(rd); s.rs1 = AW'(rs1); s.rs2 = AW'(rs2);
        return s;
    endfunction

    function automatic slot_t randomSlot();
        slot_t s;
        s.valid    = 1;
        s.rs1      = AW'($urandom_range(0, 7));
        s.rs2      = AW'($urandom_range(0, 7));
        s.rd       = AW'($urandom_range(0, 7));
        s.wen      = ($urandom_range(0, 3) != 0);
        s.isLd     = ($urandom_range(0, 5) == 0);
        s.isMem    = s.isLd || ($urandom_range(0, 7) == 0);
        s.isMulDiv = !s.isMem && ($urandom_range(0, 4) == 0);
        s.isBranch = !s.isMem && !s.isMulDiv && ($urandom_range(0, 7) == 0);
        return s;
    endfunction

    initial begin
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset.v0", int'(issueValid0), 0);
        checkOutput("reset.v1", int'(issueValid1), 0);
        checkOutput("reset.swap", int'(issueSwap), 0);
        checkOutput("reset.split", int'(splitCnt), 0);
        checkOutput("reset.stall", int'(stallCnt), 0);
        resetModel();
        @(negedge clk);
        rst = 0;

        s0 = aluOp(1, 0, 0); s1 = aluOp(2, 0, 0);
        applyStimulus("dual");
        @(negedge clk);
        s0 = aluOp(5, 1, 2); s1 = aluOp(6, 5, 7);
        applyStimulus("rawSplit");

        // Reset lands while slot 1 is still owed; it must be dropped immediately.
        #2;
        rst = 1;
        #1;
        checkOutput("midReset.v0", int'(issueValid0), 0);
        checkOutput("midReset.split", int'(splitCnt), 0);
        resetModel();
        @(negedge clk);
        rst = 0;
        s0 = '0; s1 = '0;
        applyStimulus("idle");

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (mReady || !s0.valid) begin
                s0 = randomSlot();
                s1 = randomSlot();
                s0.valid = ($urandom_range(0, 7) != 0);
                s1.valid = s0.valid && ($urandom_range(0, 3) != 0);
            end
            exRd0 = AW'($urandom_range(0, 7));
            exRd1 = AW'($urandom_range(0, 7));
            exLd0 = ($urandom_range(0, 3) == 0) && exRd0 != 0;
            exLd1 = ($urandom_range(0, 3) == 0) && exRd1 != 0;
            busy  = ($urandom_range(0, 2) == 0);
            flush = ($urandom_range(0, 15) == 0);
            applyStimulus("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
